diff_integrator: RTL and testbench
==================================

// Module: diff_integrator
// PURPOSE
//  Inverse of the difference operator: rebuilds a sample stream from its MAX_ORDER-th backward
//  difference by cascaded accumulation, one order per clock (order MAX_ORDER-1 down to 0).
//  Sits after the recovery/estimation stage, which works in the difference domain.
//  Also serves as the round-trip checker for the difference operator.
//  Initial conditions lost by differencing are restored through a seed-load port.
// PARAMETERS
//  max_order       4                   number of cascaded accumulators (>=1)
//  max_order_bits  $clog2(max_order)   index width for ld_idx / internal counter
//  OUT_RES         (functions.sv)      codebase-wide sample width; not overridden here
// PORTS
//  clk      in   1                  clock, rising edge
//  reset    in   1                  asynchronous, active-low reset
//  en       in   1                  sample strobe; d valid this cycle
//  d        in   OUT_RES signed     max_order-th difference sample
//  ld       in   1                  seed-load strobe (accepted only when idle)
//  ld_idx   in   max_order_bits+1   accumulator index 0..max_order-1 for seed
//  ld_data  in   OUT_RES signed     seed value
//  y        out  OUT_RES signed     reconstructed sample (= acc[0] after cascade)
//  valid    out  1                  one-cycle pulse: y updated
//  busy     out  1                  cascade in progress; en/ld not accepted
//  ovr      out  1                  sticky: en arrived while busy (sample dropped)
// BEHAVIOUR
//  - State: acc[max_order-1:0] signed OUT_RES; FSM IDLE/CASC; counter c.
//  - reset low (any time, incl. mid-cascade): acc[*]=0, y=0, valid=0, busy=0, ovr=0,
//    FSM=IDLE. Any in-flight sample is discarded.
//  - IDLE, en=1 at edge E0: acc[max_order-1] += d.
//    If max_order==1, y<=result and valid pulses next cycle.
//    Otherwise c<=max_order-2, FSM->CASC.
//  - CASC, each edge: acc[c] <= acc[c] + acc[c+1], using the acc[c+1] value updated on the
//    previous edge. When c==0, y takes the same sum, valid<=1 and FSM->IDLE; else c<=c-1.
//  - Latency: valid is high in the cycle after edge E0+(max_order-1), i.e. max_order edges
//    after and including E0.
//  - busy=1 in every cycle FSM==CASC; busy=0 in the valid cycle.
//    A new en in the valid cycle is accepted (back-to-back rate = 1 sample / max_order clk).
//  - en while busy: sample dropped, ovr<=1. ovr stays set until reset; acc[*] are not touched.
//  - ld in IDLE with en=0: acc[ld_idx] <= ld_data. ld_idx >= max_order is ignored.
//    ld while busy is ignored (no ovr).
//  - en and ld in the same IDLE cycle: en wins, ld is ignored.
//  - Arithmetic: OUT_RES-bit two's complement; adds wrap modulo 2^OUT_RES (see SAT_EN).
//  - y and acc hold their values between samples; valid is 0 except for the single pulse.
// CONFIGURATION
//  DIFF_INTEGRATOR_SAT_EN defined:
//    every accumulator add saturates to [-2^(OUT_RES-1), 2^(OUT_RES-1)-1].
//    Adds port sat (out, 1): sticky, set on any clipped add, cleared only by reset.
//  DIFF_INTEGRATOR_SAT_EN undefined: wrap-around adds, no sat port.
// TESTING (max_order=4, OUT_RES=16 unless noted)
//  1. Impulse: reset, seeds 0, d=1,0,0,0 on spaced en
//     -> y=1,4,10,20; each valid exactly 4 clk after en.
//  2. max_order=2, constant d=2 x3 -> y=2,6,12; busy high 1 cycle per sample.
//  3. Back-to-back: en on each valid cycle for 8 samples -> no ovr; y matches model.
//     Also en asserted while busy -> ovr=1, that sample is absent from y.
//  4. Seed + mid-cascade reset: ld acc[0]=100, then d=0 -> y=100.
//     Assert reset 2 clk after en -> valid never fires, all outputs 0.
//  5. Overflow: seed acc[0]=32767, d=1
//     -> SAT_EN: y=32767, sat=1; without SAT_EN: y=-32768.
//  6. Round trip: random 16-bit stream -> diff_operator (order 4) -> diff_integrator with
//     seeds from the first 4 samples -> y equals the original stream, wrap mode.

Source files
------------

// File: rtl/diff_integrator.sv
// diff_integrator
//   Rebuilds a sample stream from its max_order-th backward difference by
//   cascaded accumulation. An accepted sample is added into the top
//   accumulator, then one lower order is updated per clock until acc[0]
//   (the reconstructed sample) is produced on y with a one-cycle valid pulse.
//   Initial conditions lost by differencing are restored through the
//   seed-load port (ld / ld_idx / ld_data) while the block is idle.
//
// Configuration macro: DIFF_INTEGRATOR_SAT_EN
//   defined   : every accumulator add saturates; extra sticky output sat.
//   undefined : adds wrap modulo 2^OUT_RES, no sat port.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   en       in   sample strobe, d valid this cycle (dropped while busy)
//   d        in   max_order-th difference sample (signed)
//   ld       in   seed-load strobe (idle only, loses to en)
//   ld_idx   in   accumulator index for the seed (>= max_order ignored)
//   ld_data  in   seed value (signed)
//   y        out  reconstructed sample, holds between samples
//   valid    out  one-cycle pulse when y is updated
//   busy     out  cascade in progress
//   ovr      out  sticky: a sample arrived while busy and was dropped
//   sat      out  sticky: an add clipped (DIFF_INTEGRATOR_SAT_EN only)
module diff_integrator #(
  parameter int max_order      = 4,
  parameter int max_order_bits = $clog2(max_order),
  parameter int OUT_RES        = 16   // codebase-wide sample width
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic signed [OUT_RES-1:0] d,
  input  logic                      ld,
  input  logic [max_order_bits:0]   ld_idx,
  input  logic signed [OUT_RES-1:0] ld_data,
  output logic signed [OUT_RES-1:0] y,
  output logic                      valid,
  output logic                      busy,
  output logic                      ovr
`ifdef DIFF_INTEGRATOR_SAT_EN
  ,
  output logic                      sat
`endif
);

  localparam int cnt_w = max_order_bits + 1;
  localparam logic [cnt_w-1:0] top_idx = cnt_w'(max_order - 1);
  localparam logic [cnt_w-1:0] num_acc = cnt_w'(max_order);
  // First cascade step after the top accumulator handles order max_order-2.
  localparam logic [cnt_w-1:0] c_start = cnt_w'((max_order > 1) ? max_order - 2 : 0);

  typedef enum logic {IDLE, CASC} state_t;

  state_t                    state_reg, state_next;
  logic [cnt_w-1:0]          c_reg;
  logic signed [OUT_RES-1:0] acc_reg  [max_order];
  logic signed [OUT_RES-1:0] acc_next [max_order];
  logic signed [OUT_RES-1:0] y_reg;
  logic                      valid_reg;
  logic                      ovr_reg;

  logic                      take;     // sample accepted this edge
  logic                      load;     // seed write this edge
  logic                      add_we;   // shared adder result is written
  logic                      last;     // this add produces the output sample
  logic [cnt_w-1:0]          tgt_idx;
  logic signed [OUT_RES-1:0] op_a, op_b, sum;

`ifdef DIFF_INTEGRATOR_SAT_EN
  logic signed [OUT_RES:0]   sum_wide;
  logic                      clip;
  logic                      sat_reg;
`endif

  // One adder serves both the top-accumulator update (IDLE) and every
  // cascade step (CASC); only one accumulator changes per edge.
  always_comb begin
    take    = (state_reg == IDLE) && en;
    load    = (state_reg == IDLE) && !en && ld && (ld_idx < num_acc);
    add_we  = take || (state_reg == CASC);
    last    = ((state_reg == CASC) && (c_reg == '0)) || (take && (max_order == 1));
    tgt_idx = (state_reg == IDLE) ? top_idx : c_reg;

    op_a = '0;
    for (int k = 0; k < max_order; k++) begin
      if (tgt_idx == cnt_w'(k)) op_a = acc_reg[k];
    end

    op_b = d;
    if (state_reg == CASC) begin
      op_b = '0;
      for (int k = 0; k < max_order - 1; k++) begin
        if (c_reg == cnt_w'(k)) op_b = acc_reg[k+1];
      end
    end

`ifdef DIFF_INTEGRATOR_SAT_EN
    sum_wide = {op_a[OUT_RES-1], op_a} + {op_b[OUT_RES-1], op_b};
    clip     = 1'b0;
    sum      = sum_wide[OUT_RES-1:0];
    // Overflow shows as disagreement between the two top bits.
    if (sum_wide[OUT_RES] != sum_wide[OUT_RES-1]) begin
      clip = 1'b1;
      sum  = sum_wide[OUT_RES] ? {1'b1, {(OUT_RES-1){1'b0}}}
                               : {1'b0, {(OUT_RES-1){1'b1}}};
    end
`else
    sum = op_a + op_b;
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < max_order; gi++) begin : g_acc
      assign acc_next[gi] = (add_we && (tgt_idx == cnt_w'(gi))) ? sum :
                            (load && (ld_idx == cnt_w'(gi)))    ? ld_data :
                                                                  acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < max_order; k++) acc_reg[k] <= '0;
    end else begin
      for (int k = 0; k < max_order; k++) acc_reg[k] <= acc_next[k];
    end
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en && (max_order > 1)) state_next = CASC;
      CASC:    if (c_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter, output and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_reg     <= '0;
      y_reg     <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
`ifdef DIFF_INTEGRATOR_SAT_EN
      sat_reg   <= 1'b0;
`endif
    end else begin
      valid_reg <= last;
      if (last) y_reg <= sum;
      if (take)                    c_reg <= c_start;
      else if (state_reg == CASC)  c_reg <= c_reg - cnt_w'(1);
      if (en && (state_reg == CASC)) ovr_reg <= 1'b1;
`ifdef DIFF_INTEGRATOR_SAT_EN
      if (add_we && clip) sat_reg <= 1'b1;
`endif
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg == CASC);
  assign ovr   = ovr_reg;
`ifdef DIFF_INTEGRATOR_SAT_EN
  assign sat   = sat_reg;
`endif

endmodule

// File: tb/tb_diff_integrator.sv
// tb_diff_integrator
//   Directed/randomized bench for diff_integrator (max_order=4, OUT_RES=16).
//   Expected values come from constants, a cascaded-sum reference model and
//   a round trip through a 4th-order backward difference computed here.
module tb_diff_integrator;

  logic               clk;
  logic               reset;
  logic               en;
  logic signed [15:0] d;
  logic               ld;
  logic [2:0]         ld_idx;
  logic signed [15:0] ld_data;
  logic signed [15:0] y;
  logic               valid;
  logic               busy;
  logic               ovr;
`ifdef DIFF_INTEGRATOR_SAT_EN
  logic               sat;
`endif

  int checks = 0;
  int errors = 0;

  logic signed [15:0] macc [4];

  diff_integrator dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .d       (d),
    .ld      (ld),
    .ld_idx  (ld_idx),
    .ld_data (ld_data),
    .y       (y),
    .valid   (valid),
    .busy    (busy),
    .ovr     (ovr)
`ifdef DIFF_INTEGRATOR_SAT_EN
    ,
    .sat     (sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each sample adds into the top order, then every lower order
  // accumulates the order above it; the result is acc[0].
  function automatic logic signed [15:0] add16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef DIFF_INTEGRATOR_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  function automatic logic signed [15:0] model_step(input logic signed [15:0] dv);
    macc[3] = add16(macc[3], dv);
    for (int k = 2; k >= 0; k--) macc[k] = add16(macc[k], macc[k+1]);
    return macc[0];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) macc[k] = '0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  // Present one sample for one edge from idle; busy must follow.
  task automatic send(input string tag, input logic signed [15:0] dv);
    en = 1'b1;
    d  = dv;
    tick();
    en = 1'b0;
    d  = '0;
    check({tag, " busy"}, busy, 1);
  endtask

  // Wait (bounded) for valid; lat = ticks still expected after the current one.
  task automatic wait_valid(input string tag, input int lat,
                            input logic signed [15:0] exp_y);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    $display("txn %s: y=%0d expected=%0d after %0d clk", tag, y, exp_y, n);
    check({tag, " latency"}, n, lat);
    check({tag, " y"}, y, exp_y);
    check({tag, " busy@valid"}, busy, 0);
  endtask

  task automatic load_seed(input logic [2:0] idx, input logic signed [15:0] val);
    ld      = 1'b1;
    ld_idx  = idx;
    ld_data = val;
    tick();
    ld      = 1'b0;
    ld_idx  = '0;
    ld_data = '0;
  endtask

  initial begin
    logic signed [15:0] dv;
    logic signed [15:0] exp_y;
    int imp_exp [4];
    int x [24];
    int tmp;
    int vcount;

    imp_exp = '{1, 4, 10, 20};
    reset = 1'b0; en = 1'b0; d = '0; ld = 1'b0; ld_idx = '0; ld_data = '0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst y", y, 0);
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst ovr", ovr, 0);
`ifdef DIFF_INTEGRATOR_SAT_EN
    check("rst sat", sat, 0);
`endif
    reset = 1'b1;
    tick();
    check("post-rst valid", valid, 0);

    // Impulse response 1,4,10,20
    for (int i = 0; i < 4; i++) begin
      dv = (i == 0) ? 16'sd1 : 16'sd0;
      exp_y = model_step(dv);
      send("impulse", dv);
      wait_valid("impulse", 3, exp_y);
      check("impulse const", y, imp_exp[i]);
      tick();
      check("impulse pulse", valid, 0);
      tick();
    end

    // Back-to-back random samples, new sample in each valid cycle
    dv = 16'($urandom);
    exp_y = model_step(dv);
    send("b2b", dv);
    for (int i = 0; i < 8; i++) begin
      wait_valid("b2b", 3, exp_y);
      if (i < 7) begin
        dv = 16'($urandom);
        exp_y = model_step(dv);
        en = 1'b1;
        d  = dv;
        tick();
        en = 1'b0;
        d  = '0;
      end
    end
    tick();
    check("b2b ovr", ovr, 0);

    // Sample while busy is dropped and sets ovr
    dv = 16'($urandom_range(0, 200));
    exp_y = model_step(dv);
    send("drop A", dv);
    en = 1'b1;
    d  = 16'sd1234;
    tick();
    en = 1'b0;
    d  = '0;
    check("drop ovr", ovr, 1);
    wait_valid("drop A", 2, exp_y);
    tick();
    dv = 16'($urandom_range(0, 200));
    exp_y = model_step(dv);
    send("drop C", dv);
    wait_valid("drop C", 3, exp_y);
    check("drop ovr sticky", ovr, 1);

    // Seed load, ignored loads, en-over-ld priority
    do_reset();
    check("reset clears ovr", ovr, 0);
    load_seed(3'd0, 16'sd100);
    macc[0] = 16'sd100;
    load_seed(3'd4, 16'sd555);           // index out of range
    exp_y = model_step(16'sd0);
    send("seed", 16'sd0);
    wait_valid("seed", 3, exp_y);
    check("seed const", y, 100);
    tick();
    en = 1'b1; d = '0;                   // ld in same cycle must lose
    ld = 1'b1; ld_idx = 3'd3; ld_data = 16'sd77;
    tick();
    en = 1'b0; ld = 1'b0; ld_idx = '0; ld_data = '0;
    exp_y = model_step(16'sd0);
    wait_valid("en beats ld", 3, exp_y);
    tick();
    send("ld busy", 16'sd0);
    load_seed(3'd0, 16'sd999);           // busy: ignored
    exp_y = model_step(16'sd0);
    wait_valid("ld busy", 2, exp_y);
    check("ld busy const", y, 100);
    tick();

    // Reset two clocks into a cascade
    send("midrst", 16'sd5);
    en = 1'b1; d = 16'sd3;
    tick();
    en = 1'b0; d = '0;
    check("midrst ovr set", ovr, 1);
    tick();
    reset = 1'b0;
    #1;
    check("midrst y", y, 0);
    check("midrst valid", valid, 0);
    check("midrst busy", busy, 0);
    check("midrst ovr", ovr, 0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) reset = 1'b1;
      if (valid === 1'b1) vcount++;
    end
    check("midrst no valid", vcount, 0);
    model_reset();
    send("midrst acc clear", 16'sd0);
    wait_valid("midrst acc clear", 3, 16'sd0);
    tick();

    // Overflow at the positive limit
    do_reset();
    load_seed(3'd0, 16'sd32767);
    macc[0] = 16'sd32767;
    exp_y = model_step(16'sd1);
    send("ovf", 16'sd1);
    wait_valid("ovf", 3, exp_y);
`ifdef DIFF_INTEGRATOR_SAT_EN
    check("ovf sat y", y, 32767);
    check("ovf sat flag", sat, 1);
`else
    check("ovf wrap y", y, -32768);
`endif
    tick();

`ifndef DIFF_INTEGRATOR_SAT_EN
    // Round trip through a 4th-order backward difference
    do_reset();
    for (int i = 0; i < 24; i++) begin
      dv   = 16'($urandom);
      x[i] = int'(dv);
    end
    tmp = x[3];                                    load_seed(3'd0, tmp[15:0]);
    tmp = x[3] - x[2];                             load_seed(3'd1, tmp[15:0]);
    tmp = x[3] - 2*x[2] + x[1];                    load_seed(3'd2, tmp[15:0]);
    tmp = x[3] - 3*x[2] + 3*x[1] - x[0];           load_seed(3'd3, tmp[15:0]);
    for (int n = 4; n < 24; n++) begin
      tmp = x[n] - 4*x[n-1] + 6*x[n-2] - 4*x[n-3] + x[n-4];
      send("roundtrip", tmp[15:0]);
      tmp = x[n];
      wait_valid("roundtrip", 3, tmp[15:0]);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
